// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequential controller for the 16-bit shifter datapath.
// A request is latched in IDLE. The shifter then visits the power-of-two
// stages (weights 8, 4, 2, 1), one stage per cycle. The result is held in
// DONE until the consumer takes it. Status outputs are registered and
// change together with the state, so no input reaches an output
// combinationally.
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] acc_reg;
    logic [3:0]  cnt_reg;
    logic [1:0]  op_reg;
    logic [1:0]  k_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        busy_reg;

    // One candidate result per stage weight; the active stage picks one by k.
    logic [3:0][15:0] stage_res;
    logic [15:0]      stage_sel;
    logic             stage_en;

    // Build the four fixed-weight shift/rotate stages from the accumulator.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stage
            localparam int W = 1 << gi;
            assign stage_res[gi] =
                (op_reg == 2'b00) ? {acc_reg[15-W:0], acc_reg[15:16-W]} :
                (op_reg == 2'b01) ? {acc_reg[15-W:0], {W{1'b0}}} :
                (op_reg == 2'b10) ? {{W{acc_reg[15]}}, acc_reg[15:W]} :
                                    {{W{1'b0}}, acc_reg[15:W]};
        end
    endgenerate

    assign stage_sel = stage_res[k_reg];
    assign stage_en  = cnt_reg[k_reg];

    // Controller state, datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= 16'h0000;
            cnt_reg       <= 4'h0;
            op_reg        <= 2'b00;
            k_reg         <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (flush) begin
            // Abort wins over everything; datapath registers keep their value.
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg      <= In;
                        cnt_reg      <= Cnt;
                        op_reg       <= Op;
                        k_reg        <= 2'd3;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (Cnt != 4'h0) begin
                            state_reg <= SHIFT;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Every stage is visited so latency does not depend on Cnt.
                    if (stage_en) begin
                        acc_reg <= stage_sel;
                    end
                    k_reg <= k_reg - 2'd1;
                    if (k_reg == 2'd0) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign Out       = acc_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed and randomized checks of shift_seq_ctrl
// against a transaction-level reference model.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] In = 16'h0;
    logic [3:0]  Cnt = 4'h0;
    logic [1:0]  Op = 2'b00;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Out;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Cnt       (Cnt),
        .Op        (Op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-operation reference: apply the full shift amount in one step.
    function automatic logic [15:0] ref_shift(input logic [15:0] a, input int n, input logic [1:0] op);
        logic [31:0]        d;
        logic signed [15:0] s;
        logic signed [15:0] r;
        logic [15:0]        u;
        case (op)
            2'b00: begin
                d = {a, a} << n;
                return d[31:16];
            end
            2'b01: begin
                u = a << n;
                return u;
            end
            2'b10: begin
                s = a;
                r = s >>> n;
                return r;
            end
            default: begin
                u = a >> n;
                return u;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 shifting (left = stages still to go), 2 result held.
    int          m_phase = 0;
    int          m_left = 0;
    logic [15:0] m_in = 16'h0;
    logic [3:0]  m_cnt = 4'h0;
    logic [1:0]  m_op = 2'b00;
    logic [15:0] m_out = 16'h0;
    int          ntxn = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] msk;
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_in    = 16'h0;
            m_cnt   = 4'h0;
            m_op    = 2'b00;
            m_out   = 16'h0;
        end else if (flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_in  = In;
                    m_cnt = Cnt;
                    m_op  = Op;
                    m_out = In;
                    if (Cnt == 4'h0) m_phase = 2;
                    else begin
                        m_phase = 1;
                        m_left  = 4;
                    end
                end
                1: begin
                    // Stages run from weight 8 down, so after each one the
                    // accumulator holds the op applied with the high count bits seen so far.
                    m_left--;
                    msk   = 4'hF << m_left;
                    m_out = ref_shift(m_in, int'(m_cnt & msk), m_op);
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) begin
                    ntxn++;
                    $display("txn %0d: in=0x%04h cnt=%0d op=%0d out=0x%04h",
                             ntxn, m_in, m_cnt, m_op, m_out);
                    m_phase = 0;
                end
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  {15'h0, in_ready},  {15'h0, m_phase == 0});
            check("out_valid", {15'h0, out_valid}, {15'h0, m_phase == 2});
            check("busy",      {15'h0, busy},      {15'h0, m_phase != 0});
            check("Out",       Out,                m_out);
        end
    end

    task automatic send(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        #1;
        in_valid = 1'b1;
        In  = a;
        Cnt = c;
        Op  = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns the number of negedges from the accept edge until out_valid.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) return;
        end
        total++;
        bad++;
        $display("FAIL valid_timeout: out_valid got 0 expected 1");
    endtask

    task automatic take();
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                            input logic [15:0] exp, input int exp_lat, input string name);
        int n;
        send(a, c, o);
        wait_valid(n);
        check({name, "_lat"}, 16'(n), 16'(exp_lat));
        check(name, Out, exp);
        take();
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  {15'h0, in_ready},  16'h1);
        check("rst_out_valid", {15'h0, out_valid}, 16'h0);
        check("rst_busy",      {15'h0, busy},      16'h0);
        check("rst_out",       Out,                16'h0000);

        directed(16'h1234, 4'd4,  2'b00, 16'h2341, 5, "rol4");
        directed(16'h1234, 4'd4,  2'b01, 16'h2340, 5, "sll4");
        directed(16'h8000, 4'd3,  2'b10, 16'hF000, 5, "sra3");
        directed(16'h8000, 4'd15, 2'b11, 16'h0001, 5, "srl15");
        directed(16'h0001, 4'd15, 2'b00, 16'h8000, 5, "rol15");
        directed(16'hBEEF, 4'd0,  2'b10, 16'hBEEF, 1, "cnt0");

        // Backpressure with a second request presented while DONE.
        send(16'h00FF, 4'd1, 2'b01);
        wait_valid(n);
        #1;
        in_valid = 1'b1;
        In  = 16'h0F0F;
        Cnt = 4'd2;
        Op  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {15'h0, out_valid}, 16'h1);
            check("bp_out",   Out,                16'h01FE);
            check("bp_ready", {15'h0, in_ready},  16'h0);
        end
        take();
        @(negedge clk);
        check("bp_idle_ready", {15'h0, in_ready}, 16'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_second", Out, 16'h03C3);
        take();

        // Flush sampled at the end of the second SHIFT cycle.
        send(16'h5555, 4'd5, 2'b00);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_valid", {15'h0, out_valid}, 16'h0);
            check("flush_ready", {15'h0, in_ready},  16'h1);
        end
        directed(16'h00F0, 4'd4, 2'b11, 16'h000F, 5, "post_flush");

        // Asynchronous reset in the middle of SHIFT.
        send(16'hABCD, 4'd7, 2'b01);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {15'h0, in_ready},  16'h1);
        check("arst_out",   Out,                16'h0000);
        check("arst_busy",  {15'h0, busy},      16'h0);
        check("arst_valid", {15'h0, out_valid}, 16'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        directed(16'h0F00, 4'd8, 2'b00, 16'h000F, 5, "post_rst");

        // Randomized traffic: requests, backpressure and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            in_valid  = ($urandom_range(0, 1) == 1);
            In        = 16'($urandom);
            Cnt       = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            Op        = 2'($urandom);
            out_ready = ($urandom_range(0, 4) < 3);
            flush     = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequential controller for the 16-bit shifter datapath: accepts a shift request (operand, 4-bit count, 2-bit op), applies the power-of-two shift/rotate stages one per cycle (weights 8, 4, 2, 1), and returns the result through a valid/ready handshake. It sits between the execute-stage decode and the shared shifter stages, so a single stage at a time is active and one request at a time is in flight.

## Interface
Parameters: none (width fixed at 16, count fixed at 4 bits).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  controller can accept a request
- In  in  16  operand
- Cnt  in  4  shift amount, 0-15
- Op  in  2  00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical
- flush  in  1  synchronous abort of the in-flight request
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- Out  out  16  result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE. Registers: acc[15:0], cnt[3:0], op[1:0], k[1:0] (stage index).
- IDLE: in_ready=1. On in_valid at an edge: acc<=In, cnt<=Cnt, op<=Op, k<=3; next state SHIFT if Cnt!=0, else DONE.
- SHIFT: each edge, if cnt[k]=1 apply one stage of weight 2^k to acc per op, else acc holds; k<=k-1. After the k=0 edge, next state DONE.
- Stage semantics (width 16, weight w): rotate left: bits leaving [15] enter [0]; SLL: zero fill from LSB; SRA: fill with acc[15] as it stands at that stage; SRL: zero fill from MSB.
- DONE: out_valid=1, Out=acc (stable). On out_ready at an edge -> IDLE. Out holds acc in all states (registered, not cleared on leaving DONE).
- flush=1 at an edge: next state IDLE from any state, acc/cnt/op hold, no result delivered; flush has priority over acceptance and over out_ready.
- in_valid while not IDLE: ignored (in_ready=0); requester must hold it.
- Reset (rst_n=0, any time, including mid-SHIFT): immediately state IDLE, acc=0, cnt=0, op=0, k=0; in-flight request discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, Out=0x0000.
- in_ready, out_valid, busy are decoded from state only (Moore); no combinational path from any input to any output.
- Cnt!=0: accept at edge E0, SHIFT during E1..E4, out_valid=1 in the cycle after E4 (latency 4 cycles, all four stages visited regardless of which count bits are set).
- Cnt==0: out_valid=1 in the cycle after E0, Out=In.
- Result handshake at edge Ex -> in_ready=1 the cycle after Ex; next request accepted no earlier than Ex+1. Max throughput one request per 6 cycles (Cnt!=0), 2 cycles (Cnt==0).
- out_ready low: DONE holds indefinitely, Out unchanged.
- flush and rst_n do not produce out_valid.

## Test plan
- Reset then In=0x1234, Cnt=4, Op=00 -> out_valid 4 cycles after accept, Out=0x2341; Op=01 same operands -> Out=0x2340.
- In=0x8000, Cnt=3, Op=10 -> Out=0xF000; In=0x8000, Cnt=15, Op=11 -> Out=0x0001; In=0x0001, Cnt=15, Op=00 -> Out=0x8000.
- In=0xBEEF, Cnt=0, any Op -> out_valid one cycle after accept, Out=0xBEEF.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> out_valid and Out stable, in_ready=0, a second in_valid ignored; out_ready=1 -> IDLE next cycle, second request then accepted.
- flush asserted in the 2nd SHIFT cycle -> IDLE next cycle, out_valid never asserts, next request (0x00F0, Cnt=4, Op=11) -> Out=0x000F.
- rst_n pulsed low mid-SHIFT -> state IDLE, Out=0x0000, in_ready=1 immediately (asynchronous); no out_valid for the aborted request.
